// File: rtl/tdm_demux_1to4.sv
// 4-channel TDM receiver: tracks the transmitter's rotating slot select,
// collects one serial bit per slot and publishes a registered 4-bit frame word.
module tdm_demux_1to4 #(
    parameter int HOLD = 1,
    parameter int HCW  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic       SYNC,
    input  logic       D,
    output logic [1:0] S,
    output logic [3:0] Y,
    output logic       VALID,
    output logic       LOCK,
    output logic       ERR
);

    localparam logic [HCW-1:0] HLAST = HCW'(HOLD - 1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_s;
    logic [HCW-1:0] r_hc;
    logic [2:0]     r_shadow;
    logic [3:0]     r_y;
    logic           r_valid, r_err;

    logic w_samp_pt, w_bound, w_start, w_lost, w_run, w_err, w_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= HUNT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT:    if (EN && SYNC) w_state_nxt = LOCKED;
            LOCKED:  if (w_lost)     w_state_nxt = HUNT;
            default: w_state_nxt = HUNT;
        endcase
    end

    // w_start: this EN cycle becomes cycle 0 of slot 0 (acquire or realign)
    always_comb begin
        w_samp_pt = (r_hc == HLAST);
        w_bound   = (r_s == 2'd0) && (r_hc == '0);
        w_start   = EN && SYNC && ((r_state == HUNT) || !w_bound);
        w_lost    = EN && (r_state == LOCKED) && !SYNC && w_bound;
        w_run     = EN && (r_state == LOCKED) && !w_start && !w_lost;
        w_err     = w_lost || (EN && (r_state == LOCKED) && SYNC && !w_bound);
        w_lock    = (r_state == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s      <= 2'd0;
            r_hc     <= '0;
            r_shadow <= 3'b000;
            r_y      <= 4'b0000;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= EN && w_err;
            if (w_start) begin
                if (HOLD == 1) begin
                    r_shadow[0] <= D;
                    r_s         <= 2'd1;
                    r_hc        <= '0;
                end else begin
                    r_s  <= 2'd0;
                    r_hc <= HCW'(1);
                end
            end else if (w_lost) begin
                r_s  <= 2'd0;
                r_hc <= '0;
            end else if (w_run) begin
                if (w_samp_pt) begin
                    case (r_s)
                        2'd0: r_shadow[0] <= D;
                        2'd1: r_shadow[1] <= D;
                        2'd2: r_shadow[2] <= D;
                        default: begin
                            r_y     <= {D, r_shadow};
                            r_valid <= 1'b1;
                        end
                    endcase
                    r_s  <= r_s + 2'd1;
                    r_hc <= '0;
                end else begin
                    r_hc <= r_hc + HCW'(1);
                end
            end
        end
    end

    assign S     = r_s;
    assign Y     = r_y;
    assign VALID = r_valid;
    assign ERR   = r_err;
    assign LOCK  = w_lock;

endmodule

// File: doc/tdm_demux_1to4.md
Name: tdm_demux_1to4

Overview:
- Receive end of a 4-channel time-division link: the transmit side drives one serial bit per slot through a 4:1 mux with a rotating 2-bit select; this block rotates its own select, demultiplexes the serial bit into four channel positions and presents a registered 4-bit word once per frame.
- Frame alignment comes from a SYNC marker on the first cycle of slot 0.
- Sits directly downstream of the MUX_4to1-based transmitter in the lab datapath.

Parameters:
- HOLD, 1, enabled clock cycles per slot (≥1); matches the transmitter's select dwell time.
- HCW, 8, width of the internal dwell counter; must satisfy 2^HCW ≥ HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- EN  input  1  cycle enable; when low, all state is frozen.
- SYNC  input  1  frame marker; high on cycle 0 of slot 0.
- D  input  1  serial data bit from the transmitter mux output.
- S  output  2  current slot index, registered; mirrors the transmitter select.
- Y  output  4  last complete frame; Y[k] is the bit of slot k.
- VALID  output  1  one-cycle pulse: Y updated this cycle.
- LOCK  output  1  high while in LOCKED.
- ERR  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst_n low):
  - S=0, Y=4'b0000, VALID=0, ERR=0, LOCK=0.
  - Dwell counter hc=0, shadow[2:0]=0, state=HUNT.
- Reset may assert at any time mid-frame; the partial frame is discarded and no VALID is issued.
- EN=0: S, hc, shadow, Y and state hold. VALID and ERR are driven 0. SYNC and D are ignored.
- "Sample point" = an EN cycle with hc==HOLD-1. At a sample point: shadow[S]<=D (for S≤2), hc<=0, S<=S+1 (2-bit wrap 3→0). Otherwise hc<=hc+1.
- HUNT:
  - S and hc are held at 0.
  - On EN&SYNC: the cycle counts as cycle 0 of slot 0 and goes to LOCKED, with LOCK=1 from the next cycle.
  - If HOLD==1, the same cycle is a sample point: shadow[0]<=D, S<=1.
- LOCKED, end of frame: at a sample point with S==3, Y<={D,shadow[2],shadow[1],shadow[0]} and VALID=1. Both are registered, so visible the cycle after that edge. This gives a latency of one clock from the slot-3 sample edge to Y/VALID.
- LOCKED, SYNC expected (frame boundary, S==0 & hc==0 with EN):
  - SYNC=1: normal operation.
  - SYNC=0: ERR pulse, go to HUNT, LOCK=0, S=0, hc=0. D in that cycle is not sampled.
- LOCKED, SYNC unexpected (S!=0 or hc!=0 with EN):
  - ERR pulse; the partial frame is discarded, with no VALID.
  - Realign: the cycle is treated as cycle 0 of slot 0, S=0, hc=0, then the normal sample rule applies (HOLD==1 → shadow[0]<=D, S<=1). Stays LOCKED.
- Simultaneous slot-3 sample and unexpected SYNC cannot occur, because SYNC at a slot-3 sample point is itself unexpected and realign wins. Y is not updated.
- Y holds its value between frames and during HUNT; VALID is never asserted in HUNT.
- ERR and VALID are never high in the same cycle.

Test Plan:
- HOLD=1: reset, EN=1, SYNC on cycle 0, D stream 1,0,1,1 over slots 0–3 → S walks 0,1,2,3,0; VALID one cycle after the slot-3 edge with Y=4'b1101; LOCK=1; ERR=0.
- HOLD=20: SYNC on cycle 0, D held per slot at 0,1,1,0 for 20 cycles each → exactly one VALID, 80 cycles after SYNC (cycle 80), with Y=4'b0110; S changes every 20 cycles.
- HOLD=1: three back-to-back frames with SYNC every 4 cycles, words 4'hA, 4'h5, 4'hF → VALID every 4 cycles with Y=A, 5, F in order; no ERR.
- HOLD=1: SYNC withheld at the second frame boundary → ERR one-cycle pulse; LOCK drops; no further VALID until the next SYNC; Y still shows the first word.
- HOLD=1: SYNC asserted at S==2 mid-frame → ERR pulse; no VALID for the partial frame; the following 4 bits 0,0,1,0 give Y=4'b0100.
- EN=0 for 5 cycles mid-frame, then rst_n pulsed low asynchronously (between edges) → all outputs freeze during EN=0; on reset, Y=0, S=0, LOCK=0 immediately; no VALID until a new SYNC.
